proc_boot_loader: RTL and testbench

- Front end for SingleCycleProc; lets the processor be loaded and run on hardware as well as in a bench.
- Receives a byte-serial program frame and writes the instructions into the instruction memory write port.
- Holds the processor in reset for a fixed interval, then releases it with the startPC taken from the frame.
- Watches currentPC/dMemOut until the halt PC is reached, then captures the result; a watchdog flags runaway programs.

---
 rtl/proc_boot_loader.sv | 139 +++++++++++++
 tb/tb_proc_boot_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_boot_loader.sv
// Boot loader front end for SingleCycleProc: loads a byte-serial program frame into
// instruction memory, releases the processor, then watches for the halt PC or a runaway.
module proc_boot_loader #(
  parameter int          ADDR_W       = 6,
  parameter int          HOLD_CYCLES  = 2,
  parameter int          DRAIN_CYCLES = 1,
  parameter logic [15:0] WATCHDOG_MAX = 16'h1FF
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              inValid,
  input  logic [7:0]        inData,
  output logic              inReady,
  output logic              imemWE,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [31:0]       imemData,
  output logic              procReset_L,
  output logic [63:0]       startPC,
  input  logic [63:0]       currentPC,
  input  logic [63:0]       dMemOut,
  output logic [63:0]       resultOut,
  output logic [15:0]       runCycles,
  output logic              done,
  output logic              timeout,
  output logic              frameErr
);

  localparam logic [2:0] S_HDR     = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_TIMEOUT = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [16:0] MAX_WORDS  = 17'(1 << ADDR_W);

  logic [2:0]        state;
  logic [4:0]        hdr_cnt;
  logic [63:0]       halt_pc;
  logic [7:0]        n_lo;
  logic [15:0]       n_words;
  logic [ADDR_W:0]   wr_idx;
  logic [ADDR_W:0]   last_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [15:0]       tmr;
  logic [15:0]       run_inc;
  logic              take;

  assign inReady     = Reset_L && (state == S_HDR || state == S_LOAD);
  assign take        = inValid && inReady;
  assign n_words     = {inData, n_lo};
  assign procReset_L = (state == S_RUN) || (state == S_DRAIN) || (state == S_DONE);
  assign done        = (state == S_DONE);
  assign timeout     = (state == S_TIMEOUT);
  assign frameErr    = (state == S_ERROR);
  // The run counter saturates rather than wrapping.
  assign run_inc     = (runCycles == 16'hFFFF) ? runCycles : runCycles + 16'd1;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= S_HDR;
      hdr_cnt   <= '0;
      halt_pc   <= '0;
      n_lo      <= '0;
      wr_idx    <= '0;
      last_idx  <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
      tmr       <= '0;
      imemWE    <= 1'b0;
      imemAddr  <= '0;
      imemData  <= '0;
      startPC   <= '0;
      resultOut <= '0;
      runCycles <= '0;
    end else begin
      imemWE <= 1'b0;
      case (state)
        S_HDR: if (take) begin
          hdr_cnt <= hdr_cnt + 5'd1;
          // Little-endian fields: shifting in from the top leaves byte 0 at bits 7:0.
          if (hdr_cnt < 5'd8) startPC <= {inData, startPC[63:8]};
          else if (hdr_cnt < 5'd16) halt_pc <= {inData, halt_pc[63:8]};
          else if (hdr_cnt == 5'd16) n_lo <= inData;
          else begin
            last_idx <= (ADDR_W+1)'(n_words - 16'd1);
            if ({1'b0, n_words} > MAX_WORDS) state <= S_ERROR;
            else if (n_words == 16'd0) begin
              state     <= S_HOLD;
              tmr       <= '0;
              runCycles <= '0;
            end else state <= S_LOAD;
          end
        end
        S_LOAD: if (take) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imemWE   <= 1'b1;
            imemAddr <= wr_idx[ADDR_W-1:0];
            imemData <= {inData, word_buf};
            wr_idx   <= wr_idx + 1'b1;
            if (wr_idx == last_idx) begin
              state     <= S_HOLD;
              tmr       <= '0;
              runCycles <= '0;
            end
          end else word_buf <= {inData, word_buf[23:8]};
        end
        S_HOLD: begin
          if (tmr == HOLD_LAST) state <= S_RUN;
          else tmr <= tmr + 16'd1;
        end
        // Halt takes priority over the watchdog when both fire together.
        S_RUN: begin
          if (currentPC >= halt_pc) begin
            state     <= S_DRAIN;
            tmr       <= '0;
            runCycles <= run_inc;
          end else if (runCycles == WATCHDOG_MAX) state <= S_TIMEOUT;
          else runCycles <= run_inc;
        end
        S_DRAIN: begin
          runCycles <= run_inc;
          if (tmr == DRAIN_LAST) begin
            resultOut <= dMemOut;
            state     <= S_DONE;
          end else tmr <= tmr + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_boot_loader.sv
// Self-checking bench for proc_boot_loader: randomized frames against a behavioural
// model of the frame/imem writes and of when the processor run halts or times out.
module tb_proc_boot_loader;
  localparam int          ADDR_W       = 6;
  localparam int          HOLD_CYCLES  = 2;
  localparam int          DRAIN_CYCLES = 1;
  localparam logic [15:0] WD_MAX       = 16'h1FF;

  logic              CLK = 1'b0;
  logic              Reset_L = 1'b0;
  logic              inValid = 1'b0;
  logic [7:0]        inData = 8'h00;
  logic              inReady, imemWE, procReset_L, done, timeout, frameErr;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemData;
  logic [63:0]       startPC, currentPC, dMemOut, resultOut;
  logic [15:0]       runCycles;

  int checks = 0;
  int errors = 0;

  logic [63:0] pc = 64'h0;
  logic [63:0] pc_init = 64'h0;
  logic [63:0] dmem_key = 64'h0;
  bit          pc_hold = 1'b0;

  logic [7:0]        frame_q[$];
  logic [31:0]       words_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  proc_boot_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES),
                     .WATCHDOG_MAX(WD_MAX)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .inValid(inValid), .inData(inData), .inReady(inReady),
    .imemWE(imemWE), .imemAddr(imemAddr), .imemData(imemData), .procReset_L(procReset_L),
    .startPC(startPC), .currentPC(currentPC), .dMemOut(dMemOut), .resultOut(resultOut),
    .runCycles(runCycles), .done(done), .timeout(timeout), .frameErr(frameErr)
  );

  always #5 CLK = ~CLK;

  // Stand-in processor: sits at its start PC while in reset, otherwise steps by 4.
  always @(posedge CLK) begin
    if (!procReset_L || pc_hold) pc <= pc_init;
    else pc <= pc + 64'd4;
  end
  assign currentPC = pc;
  assign dMemOut   = pc ^ dmem_key;

  always @(negedge CLK) begin
    if (imemWE === 1'b1) begin
      wr_addr_q.push_back(imemAddr);
      wr_data_q.push_back(imemData);
    end
  end

  task automatic do_reset();
    inValid = 1'b0; inData = 8'h00; pc_hold = 1'b0; pc_init = 64'h0; dmem_key = 64'h0;
    Reset_L = 1'b0;
    repeat (3) @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic make_words(input int n, input bit seq);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(seq ? 32'hF800_0000 + 32'(i) : $urandom);
  endtask

  task automatic build_frame(input logic [63:0] s, input logic [63:0] h, input logic [15:0] n);
    frame_q.delete();
    for (int i = 0; i < 8; i++) frame_q.push_back(s[8*i +: 8]);
    for (int i = 0; i < 8; i++) frame_q.push_back(h[8*i +: 8]);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    foreach (words_q[w])
      for (int b = 0; b < 4; b++) frame_q.push_back(words_q[w][8*b +: 8]);
  endtask

  // Gap modes: 0 back-to-back, 1 valid every other cycle, 2 random idle cycles.
  task automatic send_frame(input int gap_mode, output int stalls, output bit ok);
    int w;
    stalls = 0; ok = 1'b1;
    foreach (frame_q[i]) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        inValid = 1'b0;
        repeat (gap_mode == 1 ? 1 : $urandom_range(1, 3)) @(negedge CLK);
      end
      inValid = 1'b1; inData = frame_q[i];
      w = 0;
      while (inReady !== 1'b1 && w < 50) begin @(negedge CLK); w++; stalls++; end
      if (inReady !== 1'b1) begin inValid = 1'b0; ok = 1'b0; return; end
      @(negedge CLK);
    end
    inValid = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    int n = 0;
    while (!(done === 1'b1 || timeout === 1'b1) && n < 3000) begin @(negedge CLK); n++; end
    ok = (done === 1'b1 || timeout === 1'b1);
  endtask

  // Run outcome from the rules alone: first run cycle k whose PC reaches haltPC, else the watchdog.
  function automatic void model_run(input logic [63:0] s, input logic [63:0] h, input bit hold,
                                    input logic [63:0] hold_pc, output bit halted,
                                    output logic [15:0] rc, output logic [63:0] cap_pc);
    logic [63:0] pc_k;
    for (int k = 0; k <= int'(WD_MAX); k++) begin
      pc_k = hold ? hold_pc : s + 64'(4 * k);
      if (pc_k >= h) begin
        halted = 1'b1;
        rc     = 16'(k + 1 + DRAIN_CYCLES);
        cap_pc = hold ? hold_pc : s + 64'(4 * (k + DRAIN_CYCLES));
        return;
      end
    end
    halted = 1'b0; rc = WD_MAX; cap_pc = 64'h0;
  endfunction

  task automatic test_reset();
    logic [187:0] outs;
    Reset_L = 1'b1;
    @(negedge CLK);
    #2 Reset_L = 1'b0;
    #1 outs = {inReady, imemWE, imemAddr, imemData, procReset_L, startPC, resultOut, runCycles,
               done, timeout, frameErr};
    checks++;
    if (outs !== '0) begin errors++; $display("[TB] FAIL reset_values: got %h expected 0", outs); end
    @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    checks++;
    if (inReady !== 1'b1 || procReset_L !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release: got inReady=%b procReset_L=%b expected 1/0", inReady, procReset_L);
    end
  endtask

  task automatic test_load(input int gap_mode);
    int stalls, lows; bit ok, halted; logic [15:0] exp_rc; logic [63:0] cap_pc;
    do_reset();
    make_words(12, 1'b1);
    build_frame(64'h0, 64'h30, 16'd12);
    model_run(64'h0, 64'h30, 1'b0, 64'h0, halted, exp_rc, cap_pc);
    pc_init = 64'h0; dmem_key = cap_pc ^ 64'hF;
    send_frame(gap_mode, stalls, ok);
    checks++;
    if (!ok || stalls != 0) begin errors++; $display("[TB] FAIL load_ready(gap %0d): got stalls=%0d ok=%b expected 0/1", gap_mode, stalls, ok); end
    checks++;
    if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL load_ready_drop: got %b expected 0", inReady); end
    lows = 0;
    while (procReset_L === 1'b0 && lows < 20) begin lows++; @(negedge CLK); end
    checks++;
    if (lows != HOLD_CYCLES) begin errors++; $display("[TB] FAIL hold_cycles: got %0d expected %0d", lows, HOLD_CYCLES); end
    checks++;
    if (wr_addr_q.size() != 12) begin errors++; $display("[TB] FAIL imem_count: got %0d expected 12", wr_addr_q.size()); end
    for (int i = 0; i < 12 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== words_q[i]) begin
        errors++; $display("[TB] FAIL imem_word%0d: got %0d:%h expected %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, words_q[i]);
      end
    end
    wait_end(ok);
    checks++;
    if (!ok || done !== 1'b1 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL load_done: got done=%b timeout=%b expected 1/0", done, timeout); end
    checks++;
    if (resultOut !== 64'hF) begin errors++; $display("[TB] FAIL load_result: got %h expected f", resultOut); end
    checks++;
    if (runCycles !== exp_rc || procReset_L !== 1'b1) begin errors++; $display("[TB] FAIL load_cycles: got %h/%b expected %h/1", runCycles, procReset_L, exp_rc); end
    repeat (3) @(negedge CLK);
    checks++;
    if (runCycles !== exp_rc || done !== 1'b1) begin errors++; $display("[TB] FAIL load_frozen: got %h/%b expected %h/1", runCycles, done, exp_rc); end
  endtask

  task automatic test_frame_error();
    int stalls; bit ok;
    do_reset();
    words_q.delete();
    build_frame(64'h10, 64'h20, 16'd65);
    send_frame(0, stalls, ok);
    checks++;
    if (!ok || frameErr !== 1'b1 || inReady !== 1'b0) begin errors++; $display("[TB] FAIL frame_err: got ok=%b frameErr=%b inReady=%b expected 1/1/0", ok, frameErr, inReady); end
    inValid = 1'b1; inData = 8'hA5;
    repeat (10) @(negedge CLK);
    inValid = 1'b0;
    checks++;
    if (wr_addr_q.size() != 0 || procReset_L !== 1'b0 || frameErr !== 1'b1) begin
      errors++; $display("[TB] FAIL frame_err_hold: got writes=%0d procReset_L=%b frameErr=%b expected 0/0/1", wr_addr_q.size(), procReset_L, frameErr);
    end
  endtask

  task automatic test_timeout();
    int stalls; bit ok, halted; logic [15:0] exp_rc; logic [63:0] cap_pc;
    do_reset();
    words_q.delete();
    build_frame(64'h0, 64'h64, 16'd0);
    model_run(64'h0, 64'h64, 1'b1, 64'h10, halted, exp_rc, cap_pc);
    pc_hold = 1'b1; pc_init = 64'h10;
    send_frame(0, stalls, ok);
    wait_end(ok);
    checks++;
    if (!ok || timeout !== !halted || done !== halted) begin errors++; $display("[TB] FAIL timeout_flag: got timeout=%b done=%b expected %b/%b", timeout, done, !halted, halted); end
    checks++;
    if (runCycles !== exp_rc || procReset_L !== 1'b0) begin errors++; $display("[TB] FAIL timeout_cycles: got %h/%b expected %h/0", runCycles, procReset_L, exp_rc); end
  endtask

  task automatic test_reset_midframe();
    int stalls; bit ok, halted; logic [15:0] exp_rc; logic [63:0] cap_pc; logic [187:0] outs;
    do_reset();
    make_words(8, 1'b0);
    build_frame(64'h80, 64'h100, 16'd8);
    while (frame_q.size() > 18 + 12 + 2) void'(frame_q.pop_back());
    send_frame(0, stalls, ok);
    #2 Reset_L = 1'b0;
    #1 outs = {inReady, imemWE, imemAddr, imemData, procReset_L, startPC, resultOut, runCycles,
               done, timeout, frameErr};
    checks++;
    if (outs !== '0) begin errors++; $display("[TB] FAIL midframe_async_reset: got %h expected 0", outs); end
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    wr_addr_q.delete(); wr_data_q.delete();
    make_words(4, 1'b0);
    build_frame(64'h40, 64'h64, 16'd4);
    model_run(64'h40, 64'h64, 1'b0, 64'h0, halted, exp_rc, cap_pc);
    pc_init = 64'h40; dmem_key = cap_pc ^ 64'h1234_5678_9abc_def0;
    send_frame(2, stalls, ok);
    checks++;
    if (startPC !== 64'h40) begin errors++; $display("[TB] FAIL refresh_startpc: got %h expected 40", startPC); end
    wait_end(ok);
    checks++;
    if (wr_addr_q.size() != 4) begin errors++; $display("[TB] FAIL refresh_count: got %0d expected 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== words_q[i]) begin
        errors++; $display("[TB] FAIL refresh_word%0d: got %0d:%h expected %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, words_q[i]);
      end
    end
    checks++;
    if (!ok || done !== 1'b1 || resultOut !== 64'h1234_5678_9abc_def0 || runCycles !== exp_rc) begin
      errors++; $display("[TB] FAIL refresh_run: got done=%b result=%h cycles=%h expected 1/123456789abcdef0/%h", done, resultOut, runCycles, exp_rc);
    end
  endtask

  task automatic test_halt_at_watchdog();
    int stalls; bit ok, halted; logic [15:0] exp_rc; logic [63:0] cap_pc;
    logic [63:0] h = 64'(4 * int'(WD_MAX));
    do_reset();
    make_words(1, 1'b0);
    build_frame(64'h0, h, 16'd1);
    model_run(64'h0, h, 1'b0, 64'h0, halted, exp_rc, cap_pc);
    pc_init = 64'h0; dmem_key = 64'h5555_0000_aaaa_0000;
    send_frame(0, stalls, ok);
    wait_end(ok);
    checks++;
    if (!ok || done !== 1'b1 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_tie_flags: got done=%b timeout=%b expected 1/0", done, timeout); end
    checks++;
    if (runCycles !== exp_rc || resultOut !== (cap_pc ^ dmem_key)) begin
      errors++; $display("[TB] FAIL wd_tie_values: got %h/%h expected %h/%h", runCycles, resultOut, exp_rc, cap_pc ^ dmem_key);
    end
  endtask

  task automatic test_random();
    int stalls, n; bit ok, halted; logic [15:0] exp_rc; logic [63:0] s, h, cap_pc;
    for (int it = 0; it < 5; it++) begin
      do_reset();
      n = $urandom_range(1, 8);
      s = {32'h0, $urandom & 32'hFFFF_FFFC};
      h = s + 64'(4 * $urandom_range(0, 60));
      make_words(n, 1'b0);
      build_frame(s, h, 16'(n));
      model_run(s, h, 1'b0, 64'h0, halted, exp_rc, cap_pc);
      pc_init = s; dmem_key = {$urandom, $urandom};
      send_frame(2, stalls, ok);
      wait_end(ok);
      checks++;
      if (wr_addr_q.size() != n) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, wr_addr_q.size(), n); end
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== words_q[i]) begin
          errors++; $display("[TB] FAIL rand%0d_word%0d: got %0d:%h expected %0d:%h", it, i, wr_addr_q[i], wr_data_q[i], i, words_q[i]);
        end
      end
      checks++;
      if (!ok || done !== 1'b1 || startPC !== s || runCycles !== exp_rc || resultOut !== (cap_pc ^ dmem_key)) begin
        errors++; $display("[TB] FAIL rand%0d_run: got done=%b pc=%h cycles=%h result=%h expected 1/%h/%h/%h", it, done, startPC, runCycles, resultOut, s, exp_rc, cap_pc ^ dmem_key);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load(0);
    test_load(1);
    test_frame_error();
    test_timeout();
    test_reset_midframe();
    test_halt_at_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
